multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control unit of the multi-cycle RV32I core; sits directly upstream of the ALU.
- A Moore FSM that sequences fetch, decode, execute, memory and writeback.
- Drives the ALU opcode, datapath mux selects, register/PC/IR write enables and the memory request handshake.
- Consumes the ALU `zero` flag to resolve branches. Counts retired instructions and flags illegal opcodes.

Parameters:
- XLEN, 32, width of the retired-instruction counter.
- RESET_IDLE_CYCLES, 1, cycles spent in IDLE after reset release before the first FETCH (≥1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store
- adr_src  out  1  0 = PC, 1 = ALU-out register
- ir_write  out  1  latch instruction and old_pc
- pc_write  out  1  write PC from the result mux
- reg_write  out  1  register-file write
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1, 11 = zero
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- result_src  out  2  00 = ALU-out register, 01 = memory data, 10 = ALU result
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J
- alu_control  out  4  ALU opcode
- illegal  out  1  sticky illegal-instruction flag
- instret  out  XLEN  retired-instruction count

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, instret = 0, illegal = 0.
  - All outputs in IDLE are 0; alu_control = ADD (0010).
  - IDLE lasts RESET_IDLE_CYCLES cycles, then FETCH.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLTU 1111, XOR 1010, SLL 1000, SRL 1001, SRA 0011.
- All outputs decode from state (plus zero, funct3 and mem_ready where stated); no output is registered separately. Unlisted outputs are 0 and alu_control = ADD.
- FETCH:
  - mem_req = 1, adr_src = 0, a = 00, b = 10, ADD, result_src = 10.
  - ir_write and pc_write are asserted only in the cycle mem_ready = 1; then go to DECODE. Otherwise hold FETCH indefinitely.
- DECODE: a = 01, b = 01, imm_src = B, ADD (branch target into ALU-out). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXE_R
  - 0010011 → EXE_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → TRAP
- MEMADR: a = 10, b = 01, ADD. imm_src = S for stores, I for loads. Next MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req = 1, adr_src = 1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src = 01, reg_write = 1 → FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. Holds until mem_ready, then FETCH.
- EXE_R / EXE_I: a = 10, b = 00 (R) or 01 (I, imm_src = I) → ALUWB. alu_control by funct3:
  - 000: ADD, or SUB when R-type and funct7b5 = 1
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when funct7b5 = 1
  - 110: OR
  - 111: AND
- ALUWB: result_src = 00, reg_write = 1 → FETCH.
- BRANCH: a = 10, b = 00, result_src = 00, pc_write = taken → FETCH. Per funct3:
  - 000 BEQ: SUB, taken = zero
  - 001 BNE: SUB, taken = !zero
  - 100 BLT: SLT, taken = !zero
  - 101 BGE: SLT, taken = zero
  - 110 BLTU: SLTU, taken = !zero
  - 111 BGEU: SLTU, taken = zero
  - 010/011: TRAP instead of FETCH; pc_write = 0.
- JAL:
  - Entered from DECODE: target = old_pc + J-imm, which DECODE must compute with imm_src = J when opcode = 1101111.
  - Entered from JALR_ADR: target is already in ALU-out.
  - Action: a = 01, b = 10, ADD (link value), result_src = 00, pc_write = 1 → ALUWB.
- JALR_ADR: a = 10, b = 01, imm_src = I, ADD → JAL. Target LSB clearing is done in the datapath.
- LUI: a = 11, b = 01, imm_src = U, ADD → ALUWB.
- AUIPC: a = 01, b = 01, imm_src = U, ADD → ALUWB.
- TRAP:
  - illegal is set to 1 on entry and stays set until reset.
  - State is absorbing; all enables 0.
- instret:
  - Increments by 1 on every transition into FETCH from any state other than IDLE.
  - Wraps from 2^XLEN − 1 to 0. Never increments in TRAP.
- Reset mid-operation (including mid-handshake with mem_ready pending): immediate return to IDLE; the pending request is dropped.

Decomposition:
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - ALU opcode localparams (shared with the ALU);
  - opcode constants;
  - mux-select and imm_src encodings.
- One sub-module, `alu_op_decoder`, is combinational: (state class, funct3, funct7b5, opcode) → alu_control.

Test Plan:
- Reset release, mem_ready held 1 → exactly 1 IDLE cycle; FETCH asserts mem_req, ir_write, pc_write in the same cycle; instret = 0.
- FETCH with mem_ready low for 3 cycles → mem_req held 4 cycles; ir_write/pc_write only in the 4th; no state advance before.
- R-type, funct3 = 000, funct7b5 = 1 → sequence FETCH, DECODE, EXE_R (alu_control = 0110), ALUWB (reg_write = 1); instret increments to 1.
- BGE (funct3 = 101) with zero = 1 → alu_control = 0111 and pc_write = 1. Same with zero = 0 → pc_write = 0. Both return to FETCH.
- JALR → JALR_ADR (ADD, b = 01), JAL (pc_write = 1, a = 01, b = 10), ALUWB (reg_write = 1); 5 cycles total with zero-wait memory.
- Opcode 1111111 → TRAP, illegal = 1, all enables 0 for 10 cycles, instret frozen; asserting rst_n = 0 clears illegal asynchronously.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit and its ALU.
package cpu_ctrl_pkg;

    // Control FSM states
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXE_R,
        S_EXE_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_ADR,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_e;

    // Selects how the ALU opcode is derived in the current state
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_FUNCT,
        ALU_CLS_BRANCH
    } alu_class_e;

    // ALU opcodes (shared with the ALU)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SRA  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Datapath mux selects
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Branch outcome from the comparison flag: BEQ/BGE/BGEU take on zero,
    // BNE/BLT/BLTU take on !zero.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        return zero ^ funct3[0] ^ funct3[2];
    endfunction

    // funct3 values 010/011 are not valid branch conditions
    function automatic logic branch_f3_valid(input logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU opcode selection from state class and instruction fields.
module alu_op_decoder
    import cpu_ctrl_pkg::*;
(
    input  alu_class_e  i_class,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7b5,
    input  logic [6:0]  i_opcode,
    output logic [3:0]  o_alu_control
);

    logic w_is_rtype;
    assign w_is_rtype = (i_opcode == OP_R);

    // Map funct3/funct7b5 onto an ALU opcode; address and link math use ADD
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_class)
            ALU_CLS_FUNCT: begin
                case (i_funct3)
                    3'b000: o_alu_control = (w_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: o_alu_control = ALU_SLL;
                    3'b010: o_alu_control = ALU_SLT;
                    3'b011: o_alu_control = ALU_SLTU;
                    3'b100: o_alu_control = ALU_XOR;
                    3'b101: o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: o_alu_control = ALU_OR;
                    3'b111: o_alu_control = ALU_AND;
                endcase
            end
            ALU_CLS_BRANCH: begin
                case (i_funct3)
                    3'b000, 3'b001: o_alu_control = ALU_SUB;
                    3'b100, 3'b101: o_alu_control = ALU_SLT;
                    3'b110, 3'b111: o_alu_control = ALU_SLTU;
                    default:        o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM of the multi-cycle RV32I core: sequencing, mux selects,
// memory handshake, retired-instruction counter and sticky illegal flag.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int XLEN              = 32,
    parameter int RESET_IDLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_write,
    output logic            adr_src,
    output logic            ir_write,
    output logic            pc_write,
    output logic            reg_write,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      result_src,
    output logic [2:0]      imm_src,
    output logic [3:0]      alu_control,
    output logic            illegal,
    output logic [XLEN-1:0] instret
);

    localparam int IDLE_W = (RESET_IDLE_CYCLES > 1) ? $clog2(RESET_IDLE_CYCLES) : 1;

    state_e            r_state;
    state_e            w_next_state;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_illegal;
    logic [XLEN-1:0]   r_instret;
    alu_class_e        w_alu_class;
    logic              w_idle_done;
    logic              w_retire;

    assign w_idle_done = (r_idle_cnt == IDLE_W'(RESET_IDLE_CYCLES - 1));
    // A return to FETCH from any working state retires one instruction
    assign w_retire    = (w_next_state == S_FETCH) && (r_state != S_IDLE) && (r_state != S_FETCH);

    assign illegal = r_illegal;
    assign instret = r_instret;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Post-reset idle timer, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
            r_illegal  <= 1'b0;
            r_instret  <= '0;
        end else begin
            if (r_state == S_IDLE)        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            if (w_next_state == S_TRAP)   r_illegal  <= 1'b1;
            if (w_retire)                 r_instret  <= r_instret + XLEN'(1);
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        result_src   = RES_ALUOUT;
        imm_src      = IMM_I;
        w_alu_class  = ALU_CLS_ADD;
        case (r_state)
            S_IDLE: begin
                if (w_idle_done) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute branch or JAL target into ALU-out
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_R:              w_next_state = S_EXE_R;
                    OP_I:              w_next_state = S_EXE_I;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR_ADR;
                    OP_LUI:            w_next_state = S_LUI;
                    OP_AUIPC:          w_next_state = S_AUIPC;
                    default:           w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_IMM;
                imm_src      = (opcode == OP_STORE) ? IMM_S : IMM_I;
                w_next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src   = RES_MEM;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) w_next_state = S_FETCH;
            end
            S_EXE_R: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_RS2;
                w_alu_class  = ALU_CLS_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXE_I: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_IMM;
                imm_src      = IMM_I;
                w_alu_class  = ALU_CLS_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                result_src   = RES_ALUOUT;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                result_src  = RES_ALUOUT;
                w_alu_class = ALU_CLS_BRANCH;
                if (branch_f3_valid(funct3)) begin
                    pc_write     = branch_taken(funct3, zero);
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_TRAP;
                end
            end
            S_JAL: begin
                // Jump to ALU-out while the ALU forms the link value old_pc + 4
                alu_src_a    = SRC_A_OLDPC;
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALUOUT;
                pc_write     = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_JALR_ADR: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_IMM;
                imm_src      = IMM_I;
                w_next_state = S_JAL;
            end
            S_LUI: begin
                alu_src_a    = SRC_A_ZERO;
                alu_src_b    = SRC_B_IMM;
                imm_src      = IMM_U;
                w_next_state = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a    = SRC_A_OLDPC;
                alu_src_b    = SRC_B_IMM;
                imm_src      = IMM_U;
                w_next_state = S_ALUWB;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    alu_op_decoder u_alu_op_decoder (
        .i_class       (w_alu_class),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_opcode      (opcode),
        .o_alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-cycle comparison against an instruction-level
// reference model, plus a narrow-counter instance to observe instret wrap.
module tb_multicycle_control;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXE,
        P_ALUWB, P_BRANCH, P_JAL, P_JALR, P_LUI, P_AUIPC, P_TRAP
    } phase_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [2:0] imm;
        logic [3:0] alu;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;

    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control;
    logic [31:0] instret;

    logic        w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write, w_illegal;
    logic [1:0]  w_alu_src_a, w_alu_src_b, w_result_src;
    logic [2:0]  w_imm_src;
    logic [3:0]  w_alu_control;
    logic [1:0]  w_instret;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_instret;
    logic        m_illegal;

    always #5 clk = ~clk;

    multicycle_control #(.XLEN(32), .RESET_IDLE_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .instret(instret)
    );

    // Narrow counter copy driven identically, so instret wrap is reachable
    multicycle_control #(.XLEN(2), .RESET_IDLE_CYCLES(1)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(w_mem_req), .mem_write(w_mem_write),
        .adr_src(w_adr_src), .ir_write(w_ir_write), .pc_write(w_pc_write), .reg_write(w_reg_write),
        .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .result_src(w_result_src),
        .imm_src(w_imm_src), .alu_control(w_alu_control), .illegal(w_illegal), .instret(w_instret)
    );

    function automatic ctl_t observed();
        ctl_t o;
        o.mem_req = mem_req;   o.mem_write = mem_write; o.adr_src = adr_src;
        o.ir_write = ir_write; o.pc_write = pc_write;   o.reg_write = reg_write;
        o.a = alu_src_a; o.b = alu_src_b; o.rs = result_src; o.imm = imm_src; o.alu = alu_control;
        return o;
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t c = '0;
        c.alu = 4'b0010;
        return c;
    endfunction

    // ALU mnemonic for OP / OP-IMM from funct3
    function automatic logic [3:0] funct_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? 4'b0110 : 4'b0010;
            3'd1:    return 4'b1000;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b1111;
            3'd4:    return 4'b1010;
            3'd5:    return f7 ? 4'b0011 : 4'b1001;
            3'd6:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] branch_alu(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd1: return 4'b0110;
            3'd4, 3'd5: return 4'b0111;
            3'd6, 3'd7: return 4'b1111;
            default:    return 4'b0010;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return !z;
            3'd5:    return z;
            3'd6:    return !z;
            3'd7:    return z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctl_t exp_ctl(input phase_e p, input logic [6:0] opc, input logic [2:0] f3,
                                     input logic f7, input logic z, input logic rdy);
        ctl_t c = idle_ctl();
        case (p)
            P_FETCH:    begin c.mem_req = 1; c.b = 2'b10; c.rs = 2'b10; c.ir_write = rdy; c.pc_write = rdy; end
            P_DECODE:   begin c.a = 2'b01; c.b = 2'b01; c.imm = (opc == 7'b1101111) ? 3'b100 : 3'b010; end
            P_MEMADR:   begin c.a = 2'b10; c.b = 2'b01; c.imm = (opc == 7'b0100011) ? 3'b001 : 3'b000; end
            P_MEMREAD:  begin c.mem_req = 1; c.adr_src = 1; end
            P_MEMWB:    begin c.rs = 2'b01; c.reg_write = 1; end
            P_MEMWRITE: begin c.mem_req = 1; c.mem_write = 1; c.adr_src = 1; end
            P_EXE: begin
                c.a = 2'b10;
                if (opc == 7'b0110011) c.b = 2'b00;
                else c.b = 2'b01;
                c.alu = funct_alu(f3, f7, opc == 7'b0110011);
            end
            P_ALUWB:    begin c.reg_write = 1; end
            P_BRANCH:   begin c.a = 2'b10; c.alu = branch_alu(f3); c.pc_write = taken(f3, z); end
            P_JAL:      begin c.a = 2'b01; c.b = 2'b10; c.pc_write = 1; end
            P_JALR:     begin c.a = 2'b10; c.b = 2'b01; end
            P_LUI:      begin c.a = 2'b11; c.b = 2'b01; c.imm = 3'b011; end
            P_AUIPC:    begin c.a = 2'b01; c.b = 2'b01; c.imm = 3'b011; end
            default:    c = idle_ctl();
        endcase
        return c;
    endfunction

    function automatic phase_e next_phase(input phase_e p, input logic [6:0] opc,
                                          input logic [2:0] f3, input logic rdy);
        case (p)
            P_FETCH:    return rdy ? P_DECODE : P_FETCH;
            P_DECODE: begin
                case (opc)
                    7'b0000011, 7'b0100011: return P_MEMADR;
                    7'b0110011, 7'b0010011: return P_EXE;
                    7'b1100011:             return P_BRANCH;
                    7'b1101111:             return P_JAL;
                    7'b1100111:             return P_JALR;
                    7'b0110111:             return P_LUI;
                    7'b0010111:             return P_AUIPC;
                    default:                return P_TRAP;
                endcase
            end
            P_MEMADR:   return (opc == 7'b0100011) ? P_MEMWRITE : P_MEMREAD;
            P_MEMREAD:  return rdy ? P_MEMWB : P_MEMREAD;
            P_MEMWRITE: return rdy ? P_FETCH : P_MEMWRITE;
            P_BRANCH:   return (f3 == 3'd2 || f3 == 3'd3) ? P_TRAP : P_FETCH;
            P_JAL:      return P_ALUWB;
            P_JALR:     return P_JAL;
            P_EXE, P_LUI, P_AUIPC: return P_ALUWB;
            P_TRAP:     return P_TRAP;
            default:    return P_FETCH;
        endcase
    endfunction

    // Run one instruction from its first FETCH cycle, comparing every cycle.
    // zmode < 0 randomises the zero flag, otherwise it is held at zmode.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input int fetch_wait, input int zmode,
                             output int cycles, output phase_e last);
        phase_e p = P_FETCH;
        phase_e np;
        ctl_t   e;
        ctl_t   o;
        int     fw = fetch_wait;
        int     n = 0;
        bit     done = 0;
        while (!done) begin
            @(negedge clk);
            opcode = opc; funct3 = f3; funct7b5 = f7;
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (p == P_FETCH) begin
                mem_ready = (fw > 0) ? 1'b0 : 1'b1;
                if (fw > 0) fw--;
            end else begin
                mem_ready = ($urandom_range(0, 2) != 0);
            end
            #1;
            e = exp_ctl(p, opc, f3, f7, zero, mem_ready);
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ctl in %s (opc=%b f3=%b): got %h expected %h", p.name(), opc, f3, o, e);
            end
            checks++;
            if (instret !== m_instret || w_instret !== m_instret[1:0] || illegal !== m_illegal) begin
                errors++;
                $display("FAIL counters in %s: instret %0d/%0d illegal %b, expected %0d/%0d illegal %b",
                         p.name(), instret, w_instret, illegal, m_instret, m_instret[1:0], m_illegal);
            end
            np = next_phase(p, opc, f3, mem_ready);
            if (np == P_FETCH && p != P_FETCH) begin m_instret++; done = 1; end
            if (np == P_TRAP) begin m_illegal = 1'b1; done = 1; end
            p = np;
            n++;
            if (n > 200 && !done) begin
                checks++; errors++;
                $display("FAIL timeout: instruction opc=%b did not complete, got >200 cycles expected <=200", opc);
                done = 1;
            end
        end
        cycles = n;
        last = p;
    endtask

    // Reset and leave the DUT in its first FETCH cycle (sampled #1 after the edge)
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        m_instret = '0; m_illegal = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
        m_instret = '0; m_illegal = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (observed() !== idle_ctl() || instret !== 32'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ctl %h instret %0d illegal %b, expected %h 0 0",
                     observed(), instret, illegal, idle_ctl());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (observed() !== idle_ctl()) begin
            errors++;
            $display("FAIL idle_cycle: got %h expected %h", observed(), idle_ctl());
        end
        @(posedge clk); #1;
        checks++;
        if (observed() !== exp_ctl(P_FETCH, opcode, 3'd0, 1'b0, 1'b0, 1'b1) || instret !== 32'd0) begin
            errors++;
            $display("FAIL first_fetch: got %h instret %0d expected %h instret 0",
                     observed(), instret, exp_ctl(P_FETCH, opcode, 3'd0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_r_sub();
        int cyc; phase_e last;
        run_instr(7'b0110011, 3'd0, 1'b1, 0, -1, cyc, last);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL r_sub_cycles: got %0d expected 4", cyc); end
        @(posedge clk); #1;
        checks++;
        if (instret !== 32'd1) begin errors++; $display("FAIL r_sub_instret: got %0d expected 1", instret); end
    endtask

    task automatic test_fetch_wait();
        int cyc; phase_e last;
        run_instr(7'b0010011, 3'd5, 1'b1, 3, -1, cyc, last);
        checks++;
        if (cyc !== 7) begin errors++; $display("FAIL fetch_wait_cycles: got %0d expected 7", cyc); end
    endtask

    task automatic test_branch_bge();
        int cyc; phase_e last;
        run_instr(7'b1100011, 3'd5, 1'b0, 0, 1, cyc, last);
        checks++;
        if (cyc !== 3 || last !== P_FETCH) begin errors++; $display("FAIL bge_taken: got %0d cycles expected 3", cyc); end
        run_instr(7'b1100011, 3'd5, 1'b0, 0, 0, cyc, last);
        checks++;
        if (cyc !== 3 || last !== P_FETCH) begin errors++; $display("FAIL bge_not_taken: got %0d cycles expected 3", cyc); end
    endtask

    task automatic test_jumps();
        int cyc; phase_e last;
        run_instr(7'b1100111, 3'd0, 1'b0, 0, -1, cyc, last);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL jalr_cycles: got %0d expected 5", cyc); end
        run_instr(7'b1101111, 3'd3, 1'b0, 0, -1, cyc, last);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL jal_cycles: got %0d expected 4", cyc); end
    endtask

    task automatic test_trap();
        int cyc; phase_e last;
        run_instr(7'b1111111, 3'd0, 1'b0, 0, -1, cyc, last);
        checks++;
        if (last !== P_TRAP || cyc !== 2) begin errors++; $display("FAIL trap_entry: got %0d cycles expected 2", cyc); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (observed() !== idle_ctl() || illegal !== 1'b1 || instret !== m_instret) begin
                errors++;
                $display("FAIL trap_hold %0d: ctl %h illegal %b instret %0d expected %h 1 %0d",
                         i, observed(), illegal, instret, idle_ctl(), m_instret);
            end
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (illegal !== 1'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL trap_async_clear: illegal %b instret %0d expected 0 0", illegal, instret);
        end
        apply_reset();
    endtask

    task automatic test_bad_branch();
        int cyc; phase_e last;
        run_instr(7'b1100011, 3'd3, 1'b0, 0, -1, cyc, last);
        checks++;
        if (last !== P_TRAP || illegal !== 1'b0) begin
            // illegal rises at the edge into TRAP, so it is still 0 here
            errors++;
            $display("FAIL bad_branch: got phase %s illegal %b expected P_TRAP 0", last.name(), illegal);
        end
        @(posedge clk); #1;
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL bad_branch_flag: got %b expected 1", illegal); end
        apply_reset();
    endtask

    task automatic test_reset_mid_handshake();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL pending_req: got %b expected 1", mem_req); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || observed() !== idle_ctl()) begin
            errors++;
            $display("FAIL reset_drop: got %h expected %h", observed(), idle_ctl());
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        int cyc; phase_e last;
        logic [6:0] opc; logic [2:0] f3;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int i = 0; i < 60; i++) begin
            opc = ops[$urandom_range(0, 8)];
            f3  = 3'($urandom_range(0, 7));
            if (opc == 7'b1100011 && (f3 == 3'd2 || f3 == 3'd3)) f3 = f3 ^ 3'b110;
            run_instr(opc, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1, cyc, last);
        end
        @(posedge clk); #1;
        checks++;
        if (instret !== m_instret || w_instret !== m_instret[1:0]) begin
            errors++;
            $display("FAIL random_instret: got %0d/%0d expected %0d/%0d", instret, w_instret, m_instret, m_instret[1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_r_sub();
        test_fetch_wait();
        test_branch_bge();
        test_jumps();
        test_random();
        test_trap();
        test_bad_branch();
        test_reset_mid_handshake();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
